// File: rtl/fp_sqrt_ctrl.sv
// rtl/fp_sqrt_ctrl.sv - single-precision square-root request controller
// Classifies operands, bypasses special cases, sequences the external datapath.
module fp_sqrt_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic [DATA_WIDTH-1:0] in_req_data,
  input  logic [TAG_WIDTH-1:0]  in_req_tag,
  input  logic                  in_flush,
  output logic                  out_sqrt_start,
  output logic [DATA_WIDTH-1:0] out_sqrt_data,
  input  logic [DATA_WIDTH-1:0] in_sqrt_data,
  input  logic                  in_sqrt_stall,
  output logic                  out_resp_valid,
  input  logic                  in_resp_ready,
  output logic [DATA_WIDTH-1:0] out_resp_data,
  output logic [TAG_WIDTH-1:0]  out_resp_tag,
  output logic [4:0]            out_resp_flags,
  output logic                  out_busy
);

  localparam int EXP_W = 8;
  localparam int MAN_W = DATA_WIDTH - EXP_W - 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] TIMEOUT_C = (CNT_W + 1)'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
  localparam logic [4:0] FLAG_NV = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;
  logic [4:0]            resp_flags_q, resp_flags_d;

  logic                  op_sign;
  logic [EXP_W-1:0]      op_exp;
  logic [MAN_W-1:0]      op_man;
  logic                  byp;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [4:0]            byp_flags;
  logic [CNT_W:0]        cnt_inc;
  logic                  cnt_expired;

  assign op_sign     = in_req_data[DATA_WIDTH-1];
  assign op_exp      = in_req_data[DATA_WIDTH-2 -: EXP_W];
  assign op_man      = in_req_data[MAN_W-1:0];
  assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_expired = (cnt_inc >= TIMEOUT_C);

  // Only positive normals need the datapath; everything else answers directly.
  always_comb begin
    byp       = 1'b1;
    byp_data  = QNAN;
    byp_flags = FLAG_NV;
    if (op_exp == '0) begin
      byp_data  = {op_sign, {(DATA_WIDTH - 1){1'b0}}};
      byp_flags = '0;
    end else if (op_exp == '1) begin
      if (op_man == '0) begin
        if (!op_sign) begin
          byp_data  = in_req_data;
          byp_flags = '0;
        end
      end else if (op_man[MAN_W-1]) begin
        byp_flags = '0;
      end
    end else if (!op_sign) begin
      byp = 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    resp_data_d    = resp_data_q;
    resp_tag_d     = resp_tag_q;
    resp_flags_d   = resp_flags_q;
    out_req_ready  = (state_q == S_IDLE) && !in_flush;
    // A flushed START never reaches the datapath, so no orphaned operation exists.
    out_sqrt_start = (state_q == S_START) && !in_flush;
    case (state_q)
      S_IDLE: begin
        if (in_req_valid && out_req_ready) begin
          op_d       = in_req_data;
          resp_tag_d = in_req_tag;
          if (byp) begin
            resp_data_d  = byp_data;
            resp_flags_d = byp_flags;
            state_d      = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (in_flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (in_flush) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if ((cnt_q != '0) && !in_sqrt_stall) begin
          resp_data_d  = in_sqrt_data;
          resp_flags_d = '0;
          state_d      = S_RESP;
        end else if (cnt_expired) begin
          resp_data_d  = QNAN;
          resp_flags_d = FLAG_NV;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      S_RESP: begin
        if (in_flush || in_resp_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!in_sqrt_stall || cnt_expired) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      resp_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      resp_flags_q <= resp_flags_d;
    end
  end

  assign out_sqrt_data  = op_q;
  assign out_resp_valid = (state_q == S_RESP);
  assign out_resp_data  = resp_data_q;
  assign out_resp_tag   = resp_tag_q;
  assign out_resp_flags = resp_flags_q;
  assign out_busy       = (state_q != S_IDLE);

endmodule

// File: doc/fp_sqrt_ctrl.md
FP_SQRT_CTRL -- requirements
Module: fp_sqrt_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (single precision).
REQ-002 SHALL have parameter TAG_WIDTH, default 5, destination-register tag width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles spent in WAIT.
REQ-004 SHALL have ports:
- in_Clk  in  1  clock; one clock, all state rising-edge.
- in_Rst_N  in  1  reset; asynchronous, active-low.
- in_req_valid  in  1  request present.
- out_req_ready  out  1  request accepted when valid&ready.
- in_req_data  in  DATA_WIDTH  operand.
- in_req_tag  in  TAG_WIDTH  destination tag.
- in_flush  in  1  kill in-flight operation.
- out_sqrt_start  out  1  start pulse to the sqrt datapath.
- out_sqrt_data  out  DATA_WIDTH  operand to the datapath.
- in_sqrt_data  in  DATA_WIDTH  datapath result.
- in_sqrt_stall  in  1  datapath busy.
- out_resp_valid  out  1  response present.
- in_resp_ready  in  1  response consumed when valid&ready.
- out_resp_data  out  DATA_WIDTH  result.
- out_resp_tag  out  TAG_WIDTH  tag of the result.
- out_resp_flags  out  5  {NV,DZ,OF,UF,NX}.
- out_busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement the states IDLE, START, WAIT, RESP, DRAIN.
REQ-006 SHALL drive out_req_ready=1 only in IDLE with in_flush=0.
REQ-007 On accept, SHALL register the operand and tag; out_sqrt_data SHALL hold the registered operand from START until the next accept.
REQ-008 On accept, SHALL classify the operand and bypass the datapath (IDLE->RESP, response valid in the next cycle) as follows:
- +0 -> +0.
- -0 -> -0.
- +inf -> 0x7F800000.
- Subnormal -> signed zero, flags 0.
- sNaN -> 0x7FC00000, NV.
- qNaN -> 0x7FC00000, flags 0.
- Negative nonzero, including -inf -> 0x7FC00000, NV.
REQ-009 A positive normal operand SHALL go IDLE->START.
REQ-010 In START, SHALL assert out_sqrt_start=1 for exactly one cycle, then go to WAIT with the cycle counter cleared to 0.
REQ-011 In WAIT, SHALL increment the counter each cycle.
REQ-012 In WAIT, when counter>=1 and in_sqrt_stall=0, SHALL capture in_sqrt_data with flags 0 and go to RESP.
REQ-013 In WAIT, if the counter reaches TIMEOUT before completion, SHALL respond with 0x7FC00000, NV, and go to RESP.
REQ-014 In RESP, SHALL hold out_resp_valid=1 and keep data, tag and flags stable until in_resp_ready=1, then go to IDLE.
REQ-015 Minimum latency: a bypass request accepted at cycle N SHALL respond at N+1; a datapath request accepted at N SHALL start at N+1.
REQ-016 in_flush SHALL have priority over all other events:
- From START or RESP: go to IDLE next cycle, no response.
- From WAIT: go to DRAIN.
- Out of IDLE: no request accepted that cycle.
REQ-017 In DRAIN, SHALL wait for in_sqrt_stall=0, or TIMEOUT cycles, then go to IDLE with no response.
REQ-018 SHALL never assert out_sqrt_start outside START, and never issue a second start before WAIT/DRAIN exits.
REQ-019 If in_flush and in_resp_ready are both high in RESP, the flush wins and the handshake does not count as consumed.
REQ-020 out_resp_data/tag/flags are don't-care while out_resp_valid=0, but SHALL be registered (no combinational path from inputs).

Reset
REQ-021 While in_Rst_N=0, SHALL asynchronously force: state=IDLE, counter=0, and out_sqrt_start, out_resp_valid, out_busy, out_resp_flags, out_resp_data, out_resp_tag, out_sqrt_data all 0.
REQ-022 Reset asserted mid-operation SHALL abandon the operation; after release, the block SHALL accept a request in the first cycle.

Verification
REQ-023 Operand 0x40800000 (4.0), tag 3; model stall high for 10 cycles after start -> one start pulse, response 0x40000000, tag 3, flags 0.
REQ-024 Operand 0xC0000000 (-2.0) -> response at N+1 of 0x7FC00000, NV=1, out_sqrt_start never asserted.
REQ-025 Operands 0x80000000, 0x7F800000, 0x7F800001 -> responses 0x80000000 flags 0, 0x7F800000 flags 0, 0x7FC00000 NV.
REQ-026 Datapath request with in_resp_ready held low for 5 cycles after completion -> valid, data and tag stable across all 5 cycles, then exactly one transfer.
REQ-027 in_flush pulsed in WAIT, stall released 4 cycles later -> no response, out_busy falls after the drain, next request accepted normally.
REQ-028 Stall stuck high -> at cycle TIMEOUT, response 0x7FC00000 with NV; reset pulsed in WAIT -> all outputs 0 immediately.
